// File: rtl/instr_class_profiler_if.sv
// Commit-stage bus observed by the instruction-class profiler.
interface instr_class_profiler_if #(
    parameter int unsigned NR_COMMIT_PORTS = 2
);
    logic [NR_COMMIT_PORTS-1:0]       commit_valid_i;
    logic [NR_COMMIT_PORTS-1:0][31:0] commit_instr_i;

    modport master (output commit_valid_i, output commit_instr_i);
    modport slave  (input  commit_valid_i, input  commit_instr_i);
endinterface

// File: rtl/instr_class_profiler.sv
// Per-class retired-instruction counters with a consistent snapshot bank.
// Two-stage pipeline: stage 0 registers commits, stage 1 classifies and accumulates.
module instr_class_profiler #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned CNT_WIDTH       = 32,
    parameter bit          SATURATE        = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    instr_class_profiler_if.slave    commit,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     snapshot_req_i,
    output logic                     snapshot_done_o,
    input  logic                     rd_en_i,
    input  logic [3:0]               rd_class_i,
    output logic [CNT_WIDTH-1:0]     rd_data_o,
    output logic                     rd_valid_o,
    output logic [15:0]              overflow_o
);

    localparam int unsigned NR_CLASSES = 16;
    localparam int unsigned IW         = $clog2(NR_COMMIT_PORTS + 1);

    typedef enum logic [3:0] {
        CLS_LOAD    = 4'd0,
        CLS_STORE   = 4'd1,
        CLS_BRANCH  = 4'd2,
        CLS_JUMP    = 4'd3,
        CLS_ALU_IMM = 4'd4,
        CLS_ALU     = 4'd5,
        CLS_MULDIV  = 4'd6,
        CLS_CSR     = 4'd7,
        CLS_SYSTEM  = 4'd8,
        CLS_FENCE   = 4'd9,
        CLS_FP      = 4'd10,
        CLS_AMO     = 4'd11,
        CLS_RVC     = 4'd12,
        CLS_DEBUG   = 4'd13,
        CLS_NOP     = 4'd14,
        CLS_OTHER   = 4'd15
    } class_e;

    typedef enum logic [6:0] {
        OPC_LOAD      = 7'b0000011,
        OPC_LOAD_FP   = 7'b0000111,
        OPC_CUSTOM0   = 7'b0001011,
        OPC_MISC_MEM  = 7'b0001111,
        OPC_OP_IMM    = 7'b0010011,
        OPC_AUIPC     = 7'b0010111,
        OPC_OP_IMM_32 = 7'b0011011,
        OPC_STORE     = 7'b0100011,
        OPC_STORE_FP  = 7'b0100111,
        OPC_AMO       = 7'b0101111,
        OPC_OP        = 7'b0110011,
        OPC_LUI       = 7'b0110111,
        OPC_OP_32     = 7'b0111011,
        OPC_MADD      = 7'b1000011,
        OPC_MSUB      = 7'b1000111,
        OPC_NMSUB     = 7'b1001011,
        OPC_NMADD     = 7'b1001111,
        OPC_OP_FP     = 7'b1010011,
        OPC_CUSTOM2   = 7'b1011011,
        OPC_BRANCH    = 7'b1100011,
        OPC_JALR      = 7'b1100111,
        OPC_JAL       = 7'b1101111,
        OPC_SYSTEM    = 7'b1110011
    } opcode_e;

    function automatic class_e classify(input logic [31:0] instr);
        class_e cls;
        if (instr[1:0] != 2'b11) begin
            cls = CLS_RVC;
        end else if (instr == 32'h0000_0013) begin
            cls = CLS_NOP;
        end else begin
            case (instr[6:0])
                OPC_LOAD, OPC_LOAD_FP:                     cls = CLS_LOAD;
                OPC_STORE, OPC_STORE_FP:                   cls = CLS_STORE;
                OPC_BRANCH:                                cls = CLS_BRANCH;
                OPC_JAL, OPC_JALR:                         cls = CLS_JUMP;
                OPC_OP_IMM, OPC_OP_IMM_32,
                OPC_LUI, OPC_AUIPC:                        cls = CLS_ALU_IMM;
                OPC_OP, OPC_OP_32:
                    cls = (instr[31:25] == 7'b0000001) ? CLS_MULDIV : CLS_ALU;
                OPC_SYSTEM:
                    cls = (instr[14:12] != 3'b000) ? CLS_CSR : CLS_SYSTEM;
                OPC_MISC_MEM:                              cls = CLS_FENCE;
                OPC_MADD, OPC_MSUB, OPC_NMSUB,
                OPC_NMADD, OPC_OP_FP:                      cls = CLS_FP;
                OPC_AMO:                                   cls = CLS_AMO;
                OPC_CUSTOM0, OPC_CUSTOM2:                  cls = CLS_DEBUG;
                default:                                   cls = CLS_OTHER;
            endcase
        end
        return cls;
    endfunction

    logic [NR_COMMIT_PORTS-1:0]       s0_valid;
    logic [NR_COMMIT_PORTS-1:0][31:0] s0_instr;
    class_e                           port_cls [NR_COMMIT_PORTS];
    logic [IW-1:0]                    inc      [NR_CLASSES];
    logic [CNT_WIDTH:0]               sum      [NR_CLASSES];
    logic [CNT_WIDTH-1:0]             live     [NR_CLASSES];
    logic [CNT_WIDTH-1:0]             next_live[NR_CLASSES];
    logic [CNT_WIDTH-1:0]             shadow   [NR_CLASSES];
    logic [15:0]                      next_ovf;

    // Stage 0: enable is applied here so commits already past it still count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s0_valid <= '0;
            s0_instr <= '0;
        end else if (clear_i) begin
            s0_valid <= '0;
            s0_instr <= '0;
        end else begin
            s0_valid <= commit.commit_valid_i & {NR_COMMIT_PORTS{enable_i}};
            s0_instr <= commit.commit_instr_i;
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
            port_cls[p] = classify(s0_instr[p]);
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NR_CLASSES; c++) begin
            inc[c] = '0;
            for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
                if (s0_valid[p] && (port_cls[p] == 4'(c))) begin
                    inc[c] = inc[c] + IW'(1);
                end
            end
        end
    end

    // Carry out of the widened sum marks overflow in both saturate and wrap modes.
    always_comb begin
        next_ovf = overflow_o;
        for (int unsigned c = 0; c < NR_CLASSES; c++) begin
            sum[c]       = {1'b0, live[c]} + (CNT_WIDTH + 1)'(inc[c]);
            next_live[c] = sum[c][CNT_WIDTH-1:0];
            if (sum[c][CNT_WIDTH]) begin
                next_ovf[c] = 1'b1;
                if (SATURATE) begin
                    next_live[c] = '1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            for (int unsigned c = 0; c < NR_CLASSES; c++) begin
                live[c] <= '0;
            end
            overflow_o <= '0;
        end else begin
            for (int unsigned c = 0; c < NR_CLASSES; c++) begin
                live[c] <= next_live[c];
            end
            overflow_o <= next_ovf;
        end
    end

    // Shadow copies pre-update live values, so a concurrent clear still lands here.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned c = 0; c < NR_CLASSES; c++) begin
                shadow[c] <= '0;
            end
        end else if (snapshot_req_i) begin
            for (int unsigned c = 0; c < NR_CLASSES; c++) begin
                shadow[c] <= live[c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            snapshot_done_o <= 1'b0;
            rd_valid_o      <= 1'b0;
            rd_data_o       <= '0;
        end else begin
            snapshot_done_o <= snapshot_req_i;
            rd_valid_o      <= rd_en_i;
            if (rd_en_i) begin
                rd_data_o <= shadow[rd_class_i];
            end
        end
    end

endmodule

// File: tb/tb_instr_class_profiler.sv
// Directed plus randomized check of instr_class_profiler in 32-bit, 8-bit saturating and 8-bit wrapping builds.
module tb_instr_class_profiler;

    localparam int unsigned NP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       enable;
    logic       clear;
    logic       snap_req;
    logic       rd_en;
    logic [3:0] rd_class;

    logic        done32, done8s, done8w;
    logic        rv32, rv8s, rv8w;
    logic [31:0] rd32;
    logic [7:0]  rd8s, rd8w;
    logic [15:0] ov32, ov8s, ov8w;

    instr_class_profiler_if #(.NR_COMMIT_PORTS(NP)) bus ();

    instr_class_profiler #(.NR_COMMIT_PORTS(NP), .CNT_WIDTH(32), .SATURATE(1'b1)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .commit(bus), .enable_i(enable), .clear_i(clear),
        .snapshot_req_i(snap_req), .snapshot_done_o(done32), .rd_en_i(rd_en), .rd_class_i(rd_class),
        .rd_data_o(rd32), .rd_valid_o(rv32), .overflow_o(ov32));

    instr_class_profiler #(.NR_COMMIT_PORTS(NP), .CNT_WIDTH(8), .SATURATE(1'b1)) dut8s (
        .clk_i(clk), .rst_ni(rst_n), .commit(bus), .enable_i(enable), .clear_i(clear),
        .snapshot_req_i(snap_req), .snapshot_done_o(done8s), .rd_en_i(rd_en), .rd_class_i(rd_class),
        .rd_data_o(rd8s), .rd_valid_o(rv8s), .overflow_o(ov8s));

    instr_class_profiler #(.NR_COMMIT_PORTS(NP), .CNT_WIDTH(8), .SATURATE(1'b0)) dut8w (
        .clk_i(clk), .rst_ni(rst_n), .commit(bus), .enable_i(enable), .clear_i(clear),
        .snapshot_req_i(snap_req), .snapshot_done_o(done8w), .rd_en_i(rd_en), .rd_class_i(rd_class),
        .rd_data_o(rd8w), .rd_valid_o(rv8w), .overflow_o(ov8w));

    // Model: unbounded totals since the last clear; width behaviour is applied at compare time.
    longint live_m [16];
    longint pend_m [16];
    longint shad_m [16];
    int     n_vec  = 0;
    int     n_fail = 0;

    function automatic int ref_class(input logic [31:0] i);
        if (i[1:0] != 2'b11) return 12;
        if (i == 32'h0000_0013) return 14;
        case (i[6:0])
            7'h03, 7'h07:                      return 0;
            7'h23, 7'h27:                      return 1;
            7'h63:                             return 2;
            7'h6F, 7'h67:                      return 3;
            7'h13, 7'h1B, 7'h37, 7'h17:        return 4;
            7'h33, 7'h3B:                      return (i[31:25] == 7'h01) ? 6 : 5;
            7'h73:                             return (i[14:12] != 3'd0) ? 7 : 8;
            7'h0F:                             return 9;
            7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53: return 10;
            7'h2F:                             return 11;
            7'h0B, 7'h5B:                      return 13;
            default:                           return 15;
        endcase
    endfunction

    function automatic longint expv(input longint total, input int w, input bit sat);
        longint lim;
        lim = longint'(1) << w;
        if (total < lim) return total;
        return sat ? lim - 1 : total % lim;
    endfunction

    function automatic logic [15:0] exp_ovf(input int w);
        logic [15:0] e;
        e = '0;
        for (int c = 0; c < 16; c++) e[c] = (live_m[c] >= (longint'(1) << w));
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [26];
        logic [31:0] r;
        int unsigned k;
        ops = '{7'h03, 7'h07, 7'h23, 7'h27, 7'h63, 7'h6F, 7'h67, 7'h13, 7'h1B, 7'h37,
                7'h17, 7'h33, 7'h3B, 7'h73, 7'h0F, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53,
                7'h2F, 7'h0B, 7'h5B, 7'h57, 7'h7F, 7'h77};
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k == 0) begin
            r[1:0] = 2'($urandom_range(0, 2));
        end else if (k == 1) begin
            r = 32'h0000_0013;
        end else begin
            r[6:0] = ops[$urandom_range(0, 25)];
            if (k == 2) r[31:25] = 7'h01;
            if (k == 3) r[14:12] = 3'd0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then check the registered outputs.
    task automatic step(input logic [NP-1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                        input logic en, input logic clr, input logic snp,
                        input logic rde, input logic [3:0] rcls);
        longint old_shad;
        bus.commit_valid_i    = v;
        bus.commit_instr_i[0] = i0;
        bus.commit_instr_i[1] = i1;
        enable   = en;
        clear    = clr;
        snap_req = snp;
        rd_en    = rde;
        rd_class = rcls;
        @(posedge clk);
        old_shad = shad_m[rcls];
        if (snp) shad_m = live_m;
        for (int c = 0; c < 16; c++) begin
            if (!clr) live_m[c] += pend_m[c];
            else      live_m[c] = 0;
            pend_m[c] = 0;
        end
        if (!clr && en) begin
            if (v[0]) pend_m[ref_class(i0)]++;
            if (v[1]) pend_m[ref_class(i1)]++;
        end
        #1;
        chk("done32", done32, snp);
        chk("done8s", done8s, snp);
        chk("done8w", done8w, snp);
        if (rde) begin
            chk("rv32", rv32, 1);
            chk("rv8s", rv8s, 1);
            chk("rv8w", rv8w, 1);
            chk("rd32", rd32, expv(old_shad, 32, 1'b1));
            chk("rd8s", rd8s, expv(old_shad, 8, 1'b1));
            chk("rd8w", rd8w, expv(old_shad, 8, 1'b0));
        end else begin
            chk("rv32_idle", rv32, 0);
        end
        bus.commit_valid_i = '0;
        clear    = 1'b0;
        snap_req = 1'b0;
        rd_en    = 1'b0;
    endtask

    task automatic idle();
        step('0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic read_cls(input logic [3:0] c);
        step('0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, c);
    endtask

    task automatic chk_ovf(input string tag);
        chk({tag, "_ov32"}, ov32, exp_ovf(32));
        chk({tag, "_ov8s"}, ov8s, exp_ovf(8));
        chk({tag, "_ov8w"}, ov8w, exp_ovf(8));
    endtask

    task automatic snap_and_check_all(input string tag);
        idle();
        step('0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int c = 0; c < 16; c++) read_cls(4'(c));
        idle();
        chk({tag, "_hold"}, rd32, expv(shad_m[15], 32, 1'b1));
        chk_ovf(tag);
    endtask

    initial begin
        for (int c = 0; c < 16; c++) begin
            live_m[c] = 0;
            pend_m[c] = 0;
            shad_m[c] = 0;
        end
        rst_n = 1'b0;
        enable = 1'b1;
        clear = 1'b0;
        snap_req = 1'b0;
        rd_en = 1'b0;
        rd_class = 4'd0;
        bus.commit_valid_i = '1;
        bus.commit_instr_i = '0;

        // Reset with commits pending on the bus: nothing may be counted.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov32", ov32, 16'h0);
        chk("rst_ov8s", ov8s, 16'h0);
        chk("rst_done", done32, 0);
        chk("rst_rv", rv32, 0);
        chk("rst_rd32", rd32, 0);
        chk("rst_rd8w", rd8w, 0);
        bus.commit_valid_i = '0;
        rst_n = 1'b1;
        snap_and_check_all("reset");

        // Decode coverage.
        step(2'b11, 32'h0000_0013, 32'h00A1_2023, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(2'b11, 32'h02B5_0533, 32'h3020_0073, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(2'b11, 32'h0000_4501, 32'h0000_000B, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        snap_and_check_all("decode");
        read_cls(4'd6);
        chk("decode_mul_const", rd32, 1);

        // Both ports hitting the branch class.
        step('0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 10; k++) step(2'b11, 32'h0000_0063, 32'h0000_0063, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        snap_and_check_all("dual");
        read_cls(4'd2);
        chk("dual_beq_const", rd32, 20);

        // 300 adds: 8-bit counters saturate or wrap, overflow flag set in both.
        step('0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 150; k++) step(2'b11, 32'h00B5_0533, 32'h00B5_0533, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        snap_and_check_all("adds");
        read_cls(4'd5);
        chk("adds_sat_const", rd8s, 255);
        chk("adds_wrap_const", rd8w, 44);
        chk("adds_w32_const", rd32, 300);
        chk("adds_ovf_sat", ov8s[5], 1);
        chk("adds_ovf_wrap", ov8w[5], 1);

        // Clear and snapshot at the same edge.
        step('0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 7; k++) step(2'b01, 32'h0010_0093, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        idle();
        step('0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        chk_ovf("collide");
        read_cls(4'd4);
        chk("collide_shadow_const", rd32, 7);
        step(2'b01, 32'h0010_0093, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        snap_and_check_all("restart");
        read_cls(4'd4);
        chk("restart_const", rd32, 1);

        // Enable gating: 5 of 20 loads dropped.
        step('0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 20; k++)
            step(2'b01, 32'h0000_2083, 32'h0, (k < 5 || k >= 10), 1'b0, 1'b0, 1'b0, 4'd0);
        snap_and_check_all("enable");
        read_cls(4'd0);
        chk("enable_const", rd32, 15);

        // Randomized traffic with interleaved clears, snapshots and reads.
        for (int k = 0; k < 400; k++) begin
            step(2'($urandom), rand_instr(), rand_instr(),
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)));
        end
        snap_and_check_all("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
